// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-core types: hazard FSM state and the NOP instruction encoding.
// Imported by the hazard controller and the IF/ID, ID/EX register stages.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  localparam int LU_CNT_W = 2;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Latency: count visible the cycle after inc; no backpressure, holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stage enables, IF/ID flush and ID/EX bubble for the five-stage core; 0-cycle latency.
// Memory busy freezes everything; redirects flush; load-use stalls PC and IF/ID.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W           = 3,
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_busy,
  input  logic             jump,
  input  logic             branch_taken,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [LU_CNT_W-1:0] LU_LOAD = LU_CNT_W'(LU_STALL_CYCLES - 1);

  hz_state_t             state_q, state_d;
  hz_state_t             saved_q, saved_d;
  hz_state_t             eff_state;
  logic [LU_CNT_W-1:0]   lu_cnt_q, lu_cnt_d;
  logic                  lu_hit;
  logic                  pc_en_c, ifid_en_c, idex_en_c, exmem_en_c;
  logic                  flush_c, bubble_c;
  logic                  flush_inc;

  assign lu_hit = ex_mem_read && (ex_rd != '0) &&
                  ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

  // Leaving MEM_WAIT resumes the saved state in the same cycle.
  assign eff_state = (state_q == HZ_MEM_WAIT) ? saved_q : state_q;

  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    lu_cnt_d   = lu_cnt_q;
    pc_en_c    = 1'b1;
    ifid_en_c  = 1'b1;
    idex_en_c  = 1'b1;
    exmem_en_c = 1'b1;
    flush_c    = 1'b0;
    bubble_c   = 1'b0;
    flush_inc  = 1'b0;

    if (mem_busy) begin
      pc_en_c    = 1'b0;
      ifid_en_c  = 1'b0;
      idex_en_c  = 1'b0;
      exmem_en_c = 1'b0;
      state_d    = HZ_MEM_WAIT;
      if (state_q != HZ_MEM_WAIT) begin
        saved_d = state_q;
      end
    end else if (branch_taken) begin
      flush_c   = 1'b1;
      bubble_c  = 1'b1;
      flush_inc = 1'b1;
      lu_cnt_d  = '0;
      state_d   = HZ_RUN;
    end else if (jump) begin
      flush_c   = 1'b1;
      flush_inc = 1'b1;
      lu_cnt_d  = '0;
      state_d   = HZ_RUN;
    end else if (eff_state == HZ_LU_STALL) begin
      pc_en_c   = 1'b0;
      ifid_en_c = 1'b0;
      bubble_c  = 1'b1;
      lu_cnt_d  = lu_cnt_q - 1'b1;
      state_d   = (lu_cnt_d == '0) ? HZ_RUN : HZ_LU_STALL;
    end else if (lu_hit) begin
      pc_en_c   = 1'b0;
      ifid_en_c = 1'b0;
      bubble_c  = 1'b1;
      lu_cnt_d  = LU_LOAD;
      state_d   = (LU_LOAD == '0) ? HZ_RUN : HZ_LU_STALL;
    end else begin
      state_d = HZ_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HZ_RUN;
      saved_q  <= HZ_RUN;
      lu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  // Reset forces a quiet pipe regardless of state or inputs.
  assign pc_en       = pc_en_c    & rst_n;
  assign ifid_en     = ifid_en_c  & rst_n;
  assign idex_en     = idex_en_c  & rst_n;
  assign exmem_en    = exmem_en_c & rst_n;
  assign ifid_flush  = flush_c    & rst_n;
  assign idex_bubble = bubble_c   & rst_n;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~pc_en),
    .clr   (cnt_clr),
    .cnt   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .clr   (cnt_clr),
    .cnt   (flush_count)
  );

endmodule
